// File: rtl/chunk_adder_if.sv
// chunk_adder_if: operand/result handshake bundle for chunk_adder.
// master drives in_valid, data_x, data_y, carry_in and out_ready.
// slave (the adder) drives in_ready, out_valid, dataOut, carry_out and overflow.
interface chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_x;
    logic [WIDTH-1:0] data_y;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataOut;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, data_x, data_y, carry_in, out_ready,
        input  in_ready, out_valid, dataOut, carry_out, overflow
    );

    modport slave (
        input  in_valid, data_x, data_y, carry_in, out_ready,
        output in_ready, out_valid, dataOut, carry_out, overflow
    );
endinterface

// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder, sums CHUNK bits per cycle over WIDTH bits.
// Ports: clk, rst (sync, active-high), bus (chunk_adder_if.slave).
// Macro CHUNK_ADDER_SAT_EN: clamp dataOut to signed max/min on overflow.
module chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic          clk,
    input logic          rst,
    chunk_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] xc, yc;
    logic [CHUNK:0]   part;
    logic             msb_cin;
    logic             last;

    assign xc   = x_q[idx_q*CHUNK +: CHUNK];
    assign yc   = y_q[idx_q*CHUNK +: CHUNK];
    assign part = {1'b0, xc} + {1'b0, yc} + {{CHUNK{1'b0}}, cy_q};
    assign last = (idx_q == IW'(NCHUNK - 1));

    // Carry into the MSB, recovered from the top bit of the last chunk.
    assign msb_cin = xc[CHUNK-1] ^ yc[CHUNK-1] ^ part[CHUNK-1];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        cy_d    = cy_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.data_x;
                    y_d     = bus.data_y;
                    cy_d    = bus.carry_in;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d[idx_q*CHUNK +: CHUNK] = part[CHUNK-1:0];
                cy_d  = part[CHUNK];
                idx_d = last ? '0 : idx_q + IW'(1);
                if (last) begin
                    // Output registers only change here, so they hold
                    // the previous result while a new sum is in flight.
                    state_d = DONE;
                    cout_d  = part[CHUNK];
                    ovf_d   = msb_cin ^ part[CHUNK];
                    dout_d  = acc_d;
`ifdef CHUNK_ADDER_SAT_EN
                    if (ovf_d) begin
                        dout_d = x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`else
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cy_q    <= 1'b0;
            acc_q   <= '0;
            dout_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cy_q    <= cy_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.dataOut   = dout_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule
